debounce_sync: RTL
==================

# debounce_sync

- Conditions a raw, asynchronous, possibly bouncing 1-bit input (push-button or external line) into a clean, synchronous, glitch-free level.
- Sits directly upstream of `edge_detect`: its `dout` drives the edge detector's `x` input.
- Contains a multi-flop synchronizer followed by a Moore debounce FSM with a consecutive-sample counter.
- `dout` only changes after the synchronized input has held a new value for a programmable number of consecutive clock cycles.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive equal samples required to accept a change; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock domain; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to `clk`.
- `din`, input, 1: raw asynchronous input.
- `dout`, output, 1: debounced level; registered, Moore.
- `busy`, output, 1: high while a candidate change is being qualified (WAIT states); registered, Moore.

## Operation

- **Synchronizer:** shift register of `SYNC_STAGES` flops; `s` denotes the last stage. It is the only consumer of `din`.
- **FSM states:**
  - STABLE_LO: `dout`=0, `busy`=0.
  - WAIT_HI: `dout`=0, `busy`=1.
  - STABLE_HI: `dout`=1, `busy`=0.
  - WAIT_LO: `dout`=1, `busy`=1.
- **Transitions**, evaluated at each rising edge using `s` and `cnt`:
  - STABLE_LO: `s`=1 → WAIT_HI, `cnt`←1. Otherwise stay, `cnt`←0.
  - WAIT_HI:
    - `s`=0 → STABLE_LO, `cnt`←0 (glitch rejected).
    - `s`=1 and `cnt`=`DEBOUNCE_CYCLES`-1 → STABLE_HI, `cnt`←0.
    - Otherwise `cnt`←`cnt`+1.
  - STABLE_HI and WAIT_LO: mirror images with the polarity of `s` inverted.
- **Counter:**
  - Never exceeds `DEBOUNCE_CYCLES`-1, so there is no wrap-around.
  - Reads 0 in both STABLE states.
- **Outputs:** decoded from state only. There is no combinational path from `din` or `s` to `dout` or `busy`.
- **Reset state:** all synchronizer flops 0, state STABLE_LO, `cnt`=0, `dout`=0, `busy`=0.
- **Reset mid-qualification** (any WAIT state): the state is discarded and the block restarts from STABLE_LO.
- **`din` held high through reset release:** `dout` rises after the full latency. A change is never suppressed because it was present at reset.
- **Illegal state encodings:** recover to STABLE_LO.

## Timing

- **Accept latency:**
  - `din` changes before rising edge 1; `s` reflects it after edge `SYNC_STAGES`.
  - `dout` changes after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`, provided `din` stays stable.
  - Defaults: 6 cycles.
- **`busy` timing:** rises after edge `SYNC_STAGES`+1 and falls on the same edge that `dout` changes.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` cycles at `s`.
- **Glitch rejection:** a pulse of ≤ `DEBOUNCE_CYCLES`-1 cycles at `s` never changes `dout`. `busy` pulses for the length of that glitch.
- **Repeated bounce:** each reversal during a WAIT state restarts qualification from zero. Accept time is measured from the last reversal.
- **Downstream interface:** `dout` changes at most once per `DEBOUNCE_CYCLES` cycles. The downstream edge detector therefore sees clean, single-cycle-separated transitions.

## Structure

- **Shared package `fsm_pkg`:**
  - State typedef `db_state_t` with 2-bit encoding: STABLE_LO=00, WAIT_HI=01, STABLE_HI=11, WAIT_LO=10.
  - Both codes with bit 1 set drive `dout`=1.
  - Shared with future FSM blocks in the codebase.
- **Sub-module `sync_ff`:**
  - Parameterised N-stage synchronizer with ports `clk`, `reset`, `d`, `q`; reset value 0.
  - Instantiated once here and reusable by other blocks.
- **Top level:** FSM, counter, and output decode live in `debounce_sync`.
- **Size:** roughly 130–180 lines of RTL total.

## Test plan

All scenarios use the default parameters and a 10 ns clock.

1. **Reset:**
   - Hold `reset`=0 with `din` toggling → `dout`=0 and `busy`=0 throughout.
   - Assert `reset` asynchronously mid-cycle → outputs clear before the next edge.
2. **Clean rise:**
   - Stimulus: `din` 0→1 before edge 1 and held.
   - Required: `busy`=1 after edge 3; `dout`=1 and `busy`=0 after edge 6. Falling edge mirrors this.
3. **Glitch:**
   - Stimulus: `din`=1 for 3 cycles, then 0.
   - Required: `dout` stays 0; `busy` high for 3 cycles then returns to 0.
4. **Bounce:**
   - Stimulus: `din` pattern 1,0,1,1,0,1, then held at 1.
   - Required: `dout` rises exactly 6 cycles after the final 0→1 transition.
5. **Reset mid-qualification:**
   - Stimulus: pull `reset` low while in WAIT_HI (`dout`=0, `busy`=1), release with `din` still 1.
   - Required: `dout`=1 six cycles after release.
6. **Chain with `edge_detect`:**
   - Stimulus: feed `dout` into `edge_detect` and drive a bouncing `din`.
   - Required: exactly one `y` pulse per accepted rise of `dout`.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared FSM types and helpers.
// Used by the debounce block and later FSM blocks.
package fsm_pkg;

  // A set bit 1 means the accepted level is high.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_t;

  function automatic logic db_level(
    input db_state_t s
  );
    return s[1];
  endfunction

  function automatic logic db_busy(
    input db_state_t s
  );
    return s[1] ^ s[0];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer.
// Clears to zero on reset.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N-2:0], d};
    end
  end

  assign q = r_sync[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizer plus Moore debounce FSM.
// Output moves only after a run of equal samples.
module debounce_sync #(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic busy
);

  import fsm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  sync_ff #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (w_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any reversal while waiting drops back and restarts from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LO;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_HI;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = STABLE_HI;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_LO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
      end
    endcase
  end

  assign dout = db_level(r_state);
  assign busy = db_busy(r_state);

endmodule
